// File: rtl/alu_mdu.sv
// EX-stage integer ALU with registered flags and an iterative
// unsigned multiply/divide unit holding architectural HI/LO.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             dz,
  output logic             out_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_ADD2 = 4'b1011;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_MFHI = 4'b1110;
  localparam logic [3:0] OP_MFLO = 4'b1111;

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE, MUL, DIV, DONE
  } state_t;

  state_t state, state_nx;

  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   opd;
  logic               div_op;

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] sum, dif;
  logic [WIDTH-1:0] alu_r;
  logic             alu_ov;
  logic             is_mc;

  logic [WIDTH:0]     madd;
  logic [WIDTH:0]     sh_r;
  logic [WIDTH:0]     dtry;
  logic [2*WIDTH-1:0] mul_nx;
  logic [2*WIDTH-1:0] div_nx;

  assign in_ready = (state == IDLE);
  assign sh  = a[SHW-1:0];
  assign sum = a + b;
  assign dif = a - b;
  assign is_mc = (aluc == OP_MULU) || (aluc == OP_DIVU);

  always_comb begin
    alu_r  = '0;
    alu_ov = 1'b0;
    case (aluc)
      OP_ADD, OP_ADD2: begin
        alu_r  = sum;
        alu_ov = (a[WIDTH-1] == b[WIDTH-1])
              && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r  = dif;
        alu_ov = (a[WIDTH-1] != b[WIDTH-1])
              && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:   alu_r = a | b;
      OP_AND:  alu_r = a & b;
      OP_XOR:  alu_r = a ^ b;
      OP_NOR:  alu_r = ~(a | b);
      OP_SLT:  alu_r[0] = $signed(a) < $signed(b);
      OP_SLTU: alu_r[0] = a < b;
      OP_SLL:  alu_r = b << sh;
      OP_SRL:  alu_r = b >> sh;
      OP_SRA:  alu_r = $signed(b) >>> sh;
      OP_MFHI: alu_r = hi;
      OP_MFLO: alu_r = lo;
      default: alu_r = '0;
    endcase
  end

  // p holds {partial, multiplier} for mul and {rem, quotient} for div
  always_comb begin
    madd   = {1'b0, p[2*WIDTH-1:WIDTH]}
           + (p[0] ? {1'b0, opd} : '0);
    mul_nx = {madd, p[WIDTH-1:1]};
    sh_r   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    dtry   = sh_r - {1'b0, opd};
    if (dtry[WIDTH])
      div_nx = {sh_r[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    else
      div_nx = {dtry[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (in_valid && aluc == OP_MULU) state_nx = MUL;
        if (in_valid && aluc == OP_DIVU) state_nx = DIV;
      end
      MUL:  if (cnt == LAST) state_nx = DONE;
      DIV:  if (cnt == LAST) state_nx = DONE;
      DONE: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      p         <= '0;
      opd       <= '0;
      div_op    <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && is_mc) begin
            div_op <= (aluc == OP_DIVU);
            cnt    <= '0;
            if (aluc == OP_DIVU) begin
              p   <= {{WIDTH{1'b0}}, a};
              opd <= b;
            end else begin
              p   <= {{WIDTH{1'b0}}, b};
              opd <= a;
            end
          end else if (in_valid) begin
            result    <= alu_r;
            zero      <= (alu_r == '0);
            ovf       <= alu_ov;
            dz        <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        MUL: begin
          p   <= mul_nx;
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          p   <= div_nx;
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          hi        <= p[2*WIDTH-1:WIDTH];
          lo        <= p[WIDTH-1:0];
          result    <= p[WIDTH-1:0];
          zero      <= (p[WIDTH-1:0] == '0);
          ovf       <= 1'b0;
          dz        <= div_op && (opd == '0);
          out_valid <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: single-cycle ops, mul/div latency,
// divide by zero, operand latching and reset mid-operation.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [3:0]  aluc;
  logic [31:0] result;
  logic        zero, ovf, dz, out_valid;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .aluc(aluc),
    .result(result), .zero(zero), .ovf(ovf), .dz(dz),
    .out_valid(out_valid), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drive at a negedge, return at the negedge after the accepting edge
  task automatic op1(input logic [3:0] op,
                     input logic [31:0] x,
                     input logic [31:0] y);
    aluc = op; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // n counts edges from acceptance (inclusive) until out_valid shows
  task automatic wait_done(input bit poke, output int n,
                           output int rdy_hi);
    n = 1;
    rdy_hi = 0;
    in_valid = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready) rdy_hi++;
      if (poke && n >= 3 && n <= 10) begin
        in_valid = 1'b1; aluc = 4'b0000;
        a = 32'h0BAD_0000 + n; b = 32'h1111;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  int n, rdy, pulses;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; aluc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result", 64'(result), 64'h0);
    chk("rst_flags", {61'h0, zero, ovf, dz}, 64'h0);
    chk("rst_ov", 64'(out_valid), 64'h0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    rst_n = 1'b1;

    op1(4'b0000, 32'h7FFF_FFFF, 32'h1);
    chk("add_ov", 64'(out_valid), 64'h1);
    chk("add_res", 64'(result), 64'h8000_0000);
    chk("add_ovf", {62'h0, ovf, zero}, 64'h2);
    op1(4'b0001, 32'd5, 32'd5);
    chk("sub_res", 64'(result), 64'h0);
    chk("sub_flags", {62'h0, ovf, zero}, 64'h1);
    op1(4'b0001, 32'h8000_0000, 32'h1);
    chk("sub_ovf", {result, 31'h0, ovf}, {32'h7FFF_FFFF, 32'h1});
    op1(4'b0110, 32'hFFFF_FFFF, 32'h1);
    chk("slt", 64'(result), 64'h1);
    op1(4'b0111, 32'hFFFF_FFFF, 32'h1);
    chk("sltu", {result, 31'h0, zero}, 64'h1);
    op1(4'b1010, 32'd4, 32'h8000_0000);
    chk("sra", 64'(result), 64'hF800_0000);
    op1(4'b1001, 32'd4, 32'h8000_0000);
    chk("srl", 64'(result), 64'h0800_0000);
    op1(4'b1000, 32'h24, 32'h0000_0003);
    chk("sll", 64'(result), 64'h0000_0030);
    op1(4'b0100, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    chk("xor", 64'(result), 64'hFF00_0FF0);
    op1(4'b0101, 32'hF0F0_0000, 32'h0F0F_0000);
    chk("nor", 64'(result), 64'h0000_FFFF);
    op1(4'b1011, 32'h7FFF_FFFF, 32'h1);
    chk("add2", {result, 31'h0, ovf}, {32'h8000_0000, 32'h1});
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ov_drop", 64'(out_valid), 64'h0);

    op1(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1'b1, n, rdy);
    chk("mul_lat", 64'(n), 64'd34);
    chk("mul_busy", 64'(rdy), 64'h0);
    chk("mul_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    chk("mul_res", {result, 31'h0, zero}, 64'h0000_0001_0000_0000);
    @(posedge clk); @(negedge clk);
    chk("mul_pulse", 64'(out_valid), 64'h0);

    op1(4'b1100, 32'd3, 32'd5);
    a = 32'hDEAD_BEEF; b = 32'h0123_4567;
    wait_done(1'b0, n, rdy);
    chk("latch_hilo", {hi, lo}, 64'd15);

    op1(4'b1101, 32'd100, 32'd7);
    wait_done(1'b0, n, rdy);
    chk("div_lat", 64'(n), 64'd34);
    chk("div_hilo", {hi, lo}, {32'd2, 32'd14});
    chk("div_dz", {result, 31'h0, dz}, {32'd14, 32'h0});
    op1(4'b1110, 32'h0, 32'h0);
    chk("mfhi", 64'(result), 64'd2);
    op1(4'b1111, 32'h0, 32'h0);
    chk("mflo", 64'(result), 64'd14);

    op1(4'b1101, 32'h1234, 32'h0);
    wait_done(1'b0, n, rdy);
    chk("dz_hilo", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
    chk("dz_flags", {61'h0, out_valid, zero, dz}, 64'h5);
    op1(4'b0011, 32'h0F, 32'hF0);
    chk("and_clr", {result, 30'h0, zero, dz}, {32'h0, 32'h2});
    in_valid = 1'b0;

    op1(4'b1100, 32'hFFFF_FFFF, 32'h2);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    rst_n = 1'b1;
    chk("rst_ready", 64'(in_ready), 64'h1);
    chk("rst_hilo2", {hi, lo}, 64'h0);
    repeat (40) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("rst_abort", 64'(pulses), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the single-cycle integer ALU for the pipelined CPU's EX stage.
- Widens the opcode to 4 bits and adds XOR/NOR, signed/unsigned compare and shifts.
- Adds registered flags and an iterative unsigned multiply/divide unit with HI/LO registers.
- Uses a valid/ready handshake so the pipeline controller can stall EX while a multi-cycle operation runs.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4, power of two).
- SHW, $clog2(WIDTH), shift-amount width in bits, taken from a[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands/opcode valid this cycle.
- in_ready  output  1  block can accept an operation (high only in IDLE).
- a  input  WIDTH  operand A; shift amount for shift ops.
- b  input  WIDTH  operand B; value shifted for shift ops.
- aluc  input  4  operation select.
- result  output  WIDTH  registered result.
- zero  output  1  registered: result == 0.
- ovf  output  1  registered signed overflow (add/sub only, else 0).
- dz  output  1  registered divide-by-zero flag (divu only, else 0).
- out_valid  output  1  one-cycle pulse: result and flags are valid.
- hi, lo  output  WIDTH each  architectural HI/LO registers.

Behaviour:
- Reset: clock and reset port names, polarity and synchronicity are fixed. Reset is synchronous and active-low: the block resets on a rising edge of clk while rst_n=0.
- Reset values: state=IDLE, result=0, zero=0, ovf=0, dz=0, out_valid=0, hi=0, lo=0, iteration counter=0.
- Reset mid-operation: any in-flight multiply/divide is aborted, no out_valid is issued, and HI/LO are cleared.
- Handshake: an operation is accepted on a clock edge where in_valid && in_ready. in_valid is ignored while in_ready=0; nothing is queued.
- Opcodes:
  - 0000 a+b; 0001 a−b; 0010 a|b; 0011 a&b; 0100 a^b; 0101 ~(a|b).
  - 0110 signed a<b → 1/0; 0111 unsigned a<b → 1/0.
  - 1000 b<<sh; 1001 b>>sh logical; 1010 b>>>sh arithmetic; sh=a[SHW-1:0].
  - 1011 a+b (reserved, same as add).
  - 1100 multu; 1101 divu; 1110 result=hi; 1111 result=lo.
- Single-cycle ops (all except 1100/1101): accepted at edge N; result, zero, ovf and dz are registered at edge N; out_valid=1 for the cycle after edge N. in_ready stays high, so back-to-back issue is allowed every cycle.
- Arithmetic: add/sub wrap modulo 2^WIDTH. ovf=1 only when both operands of the effective signed add have equal sign and the sum sign differs.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → MUL on accepted 1100; IDLE → DIV on accepted 1101; in_ready=0 outside IDLE.
  - MUL: shift-add, one multiplier bit per cycle, exactly WIDTH cycles, then → DONE.
  - DIV: restoring division, one quotient bit per cycle, exactly WIDTH cycles, then → DONE.
  - DONE: writes hi/lo, drives result=lo, out_valid=1 for one cycle, → IDLE. in_ready returns high the next cycle.
- Multi-cycle latency: accepted at edge N → out_valid high in the cycle after edge N+WIDTH+1 (WIDTH+2 cycles from issue). Operands are latched at acceptance; later changes to a/b have no effect.
- multu: {hi,lo} = a*b, full 2*WIDTH-bit unsigned product.
- divu: lo = a/b, hi = a%b, dz=0.
- Divide by zero (b=0): FSM still runs WIDTH cycles; result lo = all-ones, hi = a, dz=1.
- zero reflects the registered result on every out_valid, including mfhi/mflo and mul/div results. zero, ovf and dz hold their values between pulses.
- HI/LO are modified only in DONE or by reset.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-multu → no out_valid; hi=lo=0; in_ready=1 in the first cycle after release.
- Single-cycle ops, back-to-back:
  - add 0x7FFFFFFF+1 → result 0x80000000, ovf=1.
  - sub 5−5 → result 0, zero=1.
  - slt 0xFFFFFFFF,1 → 1; sltu same operands → 0.
  - sra b=0x80000000, a=4 → 0xF8000000.
  - Each result appears the cycle after issue.
- multu 0xFFFFFFFF*0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, out_valid exactly 34 cycles after issue. in_ready=0 throughout, and in_valid pulses during busy are ignored.
- divu 100/7 → lo=14, hi=2, dz=0. Then mfhi → result=2; mflo → result=14.
- divu 0x1234/0 → lo=0xFFFFFFFF, hi=0x1234, dz=1, zero=0.
- Change a/b during a multu in flight → product reflects the operands latched at acceptance.
